// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, issues a request-to-send and shifts one byte out on the device's clock.
// Optional build macro PS2_CLK_FILTER_EN enables an 8-sample glitch filter on the device clock.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES       = 6000,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int XFER_TIMEOUT_CYCLES  = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int MAX_AB  = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_AB > XFER_TIMEOUT_CYCLES) ? MAX_AB : XFER_TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_clk_oe;
    logic               r_dat_oe;
    logic               w_clk_oe_nxt;
    logic               w_dat_oe_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   r_xfer_cnt;
    logic [CNT_W-1:0]   w_xfer_nxt;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_nxt;
    logic               w_load;
    logic               w_xfer_to;
    logic [7:0]         r_data;
    logic               r_par;

    logic               r_clk_s1;
    logic               r_clk_s2;
    logic               r_dat_s1;
    logic               r_dat_s2;
    logic               r_clk_prev;
    logic               w_clk;
    logic               w_fall;

    // Synchronisers preset high so leaving reset never looks like a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk_in;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_dat_in;
            r_dat_s2 <= r_dat_s1;
        end
    end

`ifdef PS2_CLK_FILTER_EN
    logic       r_clk_filt;
    logic [2:0] r_filt_cnt;

    // Filtered level flips only on the 8th consecutive sample that disagrees with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_filt <= 1'b1;
            r_filt_cnt <= 3'd0;
        end else if (r_clk_s2 == r_clk_filt) begin
            r_filt_cnt <= 3'd0;
        end else if (r_filt_cnt == 3'd7) begin
            r_clk_filt <= r_clk_s2;
            r_filt_cnt <= 3'd0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 3'd1;
        end
    end

    assign w_clk = r_clk_filt;
`else
    assign w_clk = r_clk_s2;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_prev <= w_clk;
        end
    end

    assign w_fall    = r_clk_prev & ~w_clk;
    assign w_xfer_to = (r_xfer_cnt >= XFER_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_cnt      <= '0;
            r_xfer_cnt <= '0;
            r_idx      <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_oe   <= w_clk_oe_nxt;
            r_dat_oe   <= w_dat_oe_nxt;
            r_cnt      <= w_cnt_nxt;
            r_xfer_cnt <= w_xfer_nxt;
            r_idx      <= w_idx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_data <= tx_data;
            r_par  <= ~^tx_data;
        end
    end

    // Line drivers are registered, so each data bit appears the cycle after the detected fall.
    always_comb begin
        w_state_nxt  = r_state;
        w_clk_oe_nxt = r_clk_oe;
        w_dat_oe_nxt = r_dat_oe;
        w_cnt_nxt    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        w_xfer_nxt   = (r_xfer_cnt == CNT_MAX) ? r_xfer_cnt : r_xfer_cnt + 1'b1;
        w_idx_nxt    = r_idx;
        w_load       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                w_cnt_nxt    = '0;
                w_xfer_nxt   = '0;
                if (tx_valid) begin
                    w_load       = 1'b1;
                    w_state_nxt  = S_INHIBIT;
                    w_clk_oe_nxt = 1'b1;
                end
            end
            S_INHIBIT: begin
                w_xfer_nxt = '0;
                if (r_cnt >= INH_LAST) begin
                    w_state_nxt  = S_REQ;
                    w_dat_oe_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                end
            end
            S_REQ: begin
                w_state_nxt  = S_START;
                w_clk_oe_nxt = 1'b0;
                w_cnt_nxt    = '0;
                w_xfer_nxt   = '0;
            end
            S_START: begin
                w_xfer_nxt = '0;
                if (w_fall) begin
                    w_state_nxt  = S_DATA;
                    w_idx_nxt    = 3'd0;
                    w_dat_oe_nxt = ~r_data[0];
                end else if (r_cnt >= START_LAST) begin
                    w_state_nxt  = S_ERR;
                    w_clk_oe_nxt = 1'b0;
                    w_dat_oe_nxt = 1'b0;
                end
            end
            S_DATA: begin
                if (w_xfer_to) begin
                    w_state_nxt  = S_ERR;
                    w_clk_oe_nxt = 1'b0;
                    w_dat_oe_nxt = 1'b0;
                end else if (w_fall) begin
                    if (r_idx == 3'd7) begin
                        w_state_nxt  = S_PARITY;
                        w_dat_oe_nxt = ~r_par;
                    end else begin
                        w_idx_nxt    = r_idx + 3'd1;
                        w_dat_oe_nxt = ~r_data[r_idx + 3'd1];
                    end
                end
            end
            S_PARITY: begin
                if (w_xfer_to) begin
                    w_state_nxt  = S_ERR;
                    w_clk_oe_nxt = 1'b0;
                    w_dat_oe_nxt = 1'b0;
                end else if (w_fall) begin
                    w_state_nxt  = S_STOP;
                    w_dat_oe_nxt = 1'b0;
                end
            end
            S_STOP: begin
                if (w_xfer_to) begin
                    w_state_nxt  = S_ERR;
                    w_clk_oe_nxt = 1'b0;
                    w_dat_oe_nxt = 1'b0;
                end else if (w_fall) begin
                    w_state_nxt = r_dat_s2 ? S_ERR : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                if (w_xfer_to) begin
                    w_state_nxt = S_ERR;
                end else if (w_clk && r_dat_s2) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end
            S_ERR: begin
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    assign tx_ready   = (r_state == S_IDLE);
    assign tx_done    = (r_state == S_DONE);
    assign tx_error   = (r_state == S_ERR);
    assign rx_inhibit = (r_state != S_IDLE);
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;

endmodule
